pc_gen: RTL

Parametrised program-counter and fetch-request generator for the RISC-V core; it drives instruction-memory fetch addresses.
- Holds the architectural fetch PC, advances it by one fetch group when the fetch is accepted and no hazard is signalled, and redirects on branch/jump resolution or trap entry.
- Supports multi-instruction fetch groups with a slot-valid mask, plus a halt state used by debug and FFT-kernel synchronisation.
- Sits between the hazard/branch unit and the instruction memory port.

---
 rtl/pc_gen.sv | 105 ++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Program counter and fetch-request generator with group masks and halt.
// Ports: clk, rst(async low), pc_hazarded, redirect_*, trap_valid, halt_req, fetch_ready -> fetch_*, misalign_err, halted, fetch_count.
module pc_gen #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned FETCH_WIDTH = 1,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int unsigned CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pc_hazarded,
  input  logic redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic trap_valid,
  input  logic halt_req,
  input  logic fetch_ready,
  output logic fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [FETCH_WIDTH-1:0] fetch_mask,
  output logic misalign_err,
  output logic halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [XLEN-1:0] GSIZE = XLEN'(4 * FETCH_WIDTH);
  localparam logic [XLEN-1:0] GMASK = XLEN'(4 * FETCH_WIDTH - 1);
  localparam logic [XLEN-1:0] OMASK = XLEN'(FETCH_WIDTH - 1);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t state;
  state_t state_nxt;
  logic accept;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] pc_nxt;
  logic err_nxt;

  // Slots before the word offset inside the group are not valid.
  function automatic logic [FETCH_WIDTH-1:0] mask_of(
    input logic [XLEN-1:0] pc
  );
    logic [XLEN-1:0] off;
    logic [FETCH_WIDTH-1:0] m;
    off = (pc >> 2) & OMASK;
    for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
      m[i] = (XLEN'(i) >= off);
    end
    return m;
  endfunction

  assign accept = (state == RUN) && fetch_valid
    && fetch_ready && !pc_hazarded;
  assign seq_pc = (fetch_pc & ~GMASK) + GSIZE;

  always_comb begin
    pc_nxt = fetch_pc;
    err_nxt = 1'b0;
    if (trap_valid) begin
      pc_nxt = TRAP_VECTOR;
    end else if (redirect_valid) begin
      pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
      err_nxt = (redirect_pc[1:0] != 2'b00);
    end else if (accept) begin
      pc_nxt = seq_pc;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT: state_nxt = halt_req ? HALT : RUN;
      RUN: state_nxt = halt_req ? HALT : RUN;
      HALT: begin
        if (!halt_req || trap_valid) state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      fetch_pc <= RESET_VECTOR;
      fetch_mask <= mask_of(RESET_VECTOR);
      fetch_valid <= 1'b0;
      misalign_err <= 1'b0;
      halted <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      fetch_pc <= pc_nxt;
      fetch_mask <= mask_of(pc_nxt);
      fetch_valid <= (state_nxt == RUN);
      halted <= (state_nxt == HALT);
      misalign_err <= err_nxt;
      if (accept) fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule
